// File: rtl/adc082s021_responder_if.sv
// rtl/adc082s021_responder_if.sv - SPI pin bundle between a master driver and the ADC082S021 responder
interface adc082s021_responder_if;
    logic ss_n;
    logic sclk;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (
        output ss_n,
        output sclk,
        output mosi,
        input  miso,
        input  miso_oe
    );

    modport slave (
        input  ss_n,
        input  sclk,
        input  mosi,
        output miso,
        output miso_oe
    );
endinterface

// File: rtl/adc082s021_responder.sv
// rtl/adc082s021_responder.sv - oversampled SPI responder emulating the ADC082S021 converter
module adc082s021_responder #(
    parameter int NCHAN = 2,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    adc082s021_responder_if.slave    spi,
    input  logic [NCHAN*WIDTH-1:0]   samples,
    output logic [2:0]               cur_channel,
    output logic                     frame_done,
    output logic                     frame_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t      state, state_n;
    logic [2:0]  ss_sh, sclk_sh;
    logic [1:0]  mosi_sh;
    logic [14:0] out_reg, out_n;
    logic [12:0] in_reg, in_n;
    logic [4:0]  cnt, cnt_n;
    logic        miso_n, oe_n, done_n, err_n;
    logic [2:0]  cur_n;
    logic [WIDTH-1:0] sel;
    logic [15:0] snap;

    logic ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;

    // ss_n chain resets to "selected" so a frame already in progress when reset
    // releases shows no falling edge; the next frame needs a fresh high-then-low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ss_sh   <= 3'b000;
            sclk_sh <= 3'b111;
            mosi_sh <= 2'b00;
        end else begin
            ss_sh   <= {ss_sh[1:0], spi.ss_n};
            sclk_sh <= {sclk_sh[1:0], spi.sclk};
            mosi_sh <= {mosi_sh[0], spi.mosi};
        end
    end

    assign ss_fall   =  ss_sh[2]   & ~ss_sh[1];
    assign ss_rise   = ~ss_sh[2]   &  ss_sh[1];
    assign sclk_rise = ~sclk_sh[2] &  sclk_sh[1];
    assign sclk_fall =  sclk_sh[2] & ~sclk_sh[1];
    assign mosi_s    =  mosi_sh[1];

    always_comb begin
        sel = '0;
        for (int k = 0; k < NCHAN; k++) begin
            if (cur_channel == 3'(k))
                sel = samples[k*WIDTH +: WIDTH];
        end
        snap = 16'(sel) << (12 - WIDTH);
    end

    always_comb begin
        state_n = state;
        out_n   = out_reg;
        in_n    = in_reg;
        cnt_n   = cnt;
        miso_n  = spi.miso;
        oe_n    = spi.miso_oe;
        cur_n   = cur_channel;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_n = SHIFT;
                    out_n   = snap[14:0];
                    in_n    = '0;
                    miso_n  = snap[15];
                    oe_n    = 1'b1;
                    cnt_n   = '0;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_n = IDLE;
                    oe_n    = 1'b0;
                    miso_n  = 1'b0;
                    err_n   = 1'b1;
                end else if (sclk_rise) begin
                    // Only frame bits 12..0 are kept; bits 13..11 land in in_reg[12:10] at the 16th edge.
                    in_n  = {in_reg[11:0], mosi_s};
                    cnt_n = cnt + 5'd1;
                    if (cnt == 5'd15) begin
                        state_n = HOLD;
                        cur_n   = in_reg[12:10];
                        done_n  = 1'b1;
                        miso_n  = 1'b0;
                    end
                end else if (sclk_fall && cnt != 5'd0) begin
                    out_n  = {out_reg[13:0], 1'b0};
                    miso_n = out_reg[14];
                end
            end
            HOLD: begin
                if (ss_rise) begin
                    state_n = IDLE;
                    oe_n    = 1'b0;
                    miso_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            out_reg     <= '0;
            in_reg      <= '0;
            cnt         <= '0;
            spi.miso    <= 1'b0;
            spi.miso_oe <= 1'b0;
            cur_channel <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_n;
            out_reg     <= out_n;
            in_reg      <= in_n;
            cnt         <= cnt_n;
            spi.miso    <= miso_n;
            spi.miso_oe <= oe_n;
            cur_channel <= cur_n;
            frame_done  <= done_n;
            frame_err   <= err_n;
        end
    end

endmodule

// File: tb/tb_adc082s021_responder.sv
// tb/tb_adc082s021_responder.sv - directed self-checking bench for adc082s021_responder
module tb_adc082s021_responder;
    localparam int HALF = 80;

    logic        clk;
    logic        reset;
    logic [23:0] samples;
    logic [2:0]  cur_channel;
    logic        frame_done;
    logic        frame_err;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    adc082s021_responder_if spi ();

    adc082s021_responder #(.NCHAN(2), .WIDTH(12)) dut (
        .clk         (clk),
        .reset       (reset),
        .spi         (spi.slave),
        .samples     (samples),
        .cur_channel (cur_channel),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic spi_frame(input logic [15:0] tx, input int nrise, input logic chg,
                             output logic [15:0] rx, output logic [3:0] extra, output logic oe_mid);
        rx = '0;
        extra = '0;
        oe_mid = 1'b0;
        spi.ss_n = 1'b0;
        #(HALF);
        if (chg) samples = 24'hABC_DEF;
        for (int i = 0; i < nrise; i++) begin
            spi.sclk = 1'b0;
            spi.mosi = (i < 16) ? tx[15-i] : 1'b1;
            #(HALF);
            if (i < 16) rx[15-i] = spi.miso;
            else        extra[i-16] = spi.miso;
            if (i == 0) oe_mid = spi.miso_oe;
            spi.sclk = 1'b1;
            #(HALF);
        end
        spi.ss_n = 1'b1;
        #(2*HALF);
    endtask

    logic [15:0] rx;
    logic [3:0]  extra;
    logic        oe_mid;
    int          d0, e0;

    initial begin
        reset    = 1'b0;
        spi.ss_n = 1'b1;
        spi.sclk = 1'b1;
        spi.mosi = 1'b0;
        samples  = {12'h5A3, 12'h1FF};
        repeat (3) @(negedge clk);
        check("rst_miso",    16'(spi.miso),    16'h0);
        check("rst_oe",      16'(spi.miso_oe), 16'h0);
        check("rst_cur",     16'(cur_channel), 16'h0);
        check("rst_done",    16'(frame_done),  16'h0);
        check("rst_err",     16'(frame_err),   16'h0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // frame 1: ch0 data, address 1
        d0 = done_cnt; e0 = err_cnt;
        spi_frame(16'h0800, 16, 1'b0, rx, extra, oe_mid);
        check("f1_rx",    rx, 16'h01FF);
        check("f1_oe",    16'(oe_mid), 16'h1);
        check("f1_oeoff", 16'(spi.miso_oe), 16'h0);
        check("f1_done",  16'(done_cnt - d0), 16'h1);
        check("f1_err",   16'(err_cnt - e0), 16'h0);
        check("f1_cur",   16'(cur_channel), 16'h1);

        // frame 2: ch1 data; samples change after ss_n fall must not leak in
        spi_frame(16'h0000, 16, 1'b1, rx, extra, oe_mid);
        check("f2_rx",  rx, 16'h05A3);
        check("f2_cur", 16'(cur_channel), 16'h0);
        samples = {12'h5A3, 12'h1FF};

        // short frame leaves cur_channel untouched
        spi_frame(16'h0800, 16, 1'b0, rx, extra, oe_mid);
        check("f3a_rx", rx, 16'h01FF);
        d0 = done_cnt; e0 = err_cnt;
        spi_frame(16'h0000, 9, 1'b0, rx, extra, oe_mid);
        check("f3_err",  16'(err_cnt - e0), 16'h1);
        check("f3_done", 16'(done_cnt - d0), 16'h0);
        check("f3_cur",  16'(cur_channel), 16'h1);

        // out-of-range channel 7 returns zero
        spi_frame(16'h3800, 16, 1'b0, rx, extra, oe_mid);
        check("f4a_rx",  rx, 16'h05A3);
        check("f4a_cur", 16'(cur_channel), 16'h7);
        spi_frame(16'h0000, 16, 1'b0, rx, extra, oe_mid);
        check("f4_rx",  rx, 16'h0000);
        check("f4_cur", 16'(cur_channel), 16'h0);

        // 20 edges: one done, extra bits zero, address 2
        d0 = done_cnt;
        spi_frame(16'h1000, 20, 1'b0, rx, extra, oe_mid);
        check("f5_rx",    rx, 16'h01FF);
        check("f5_extra", 16'(extra), 16'h0);
        check("f5_done",  16'(done_cnt - d0), 16'h1);
        check("f5_cur",   16'(cur_channel), 16'h2);

        // reset mid-frame after 5 edges
        @(negedge clk);
        spi.ss_n = 1'b0;
        #(HALF);
        for (int i = 0; i < 5; i++) begin
            spi.sclk = 1'b0; #(HALF);
            spi.sclk = 1'b1; #(HALF);
        end
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("r6_miso", 16'(spi.miso),    16'h0);
        check("r6_oe",   16'(spi.miso_oe), 16'h0);
        check("r6_cur",  16'(cur_channel), 16'h0);
        reset = 1'b1;
        d0 = done_cnt; e0 = err_cnt;
        for (int i = 0; i < 11; i++) begin
            spi.sclk = 1'b0; #(HALF);
            spi.sclk = 1'b1; #(HALF);
        end
        check("r6_oe_rest", 16'(spi.miso_oe), 16'h0);
        spi.ss_n = 1'b1;
        #(2*HALF);
        check("r6_done", 16'(done_cnt - d0), 16'h0);
        check("r6_err",  16'(err_cnt - e0), 16'h0);
        spi_frame(16'h0000, 16, 1'b0, rx, extra, oe_mid);
        check("r6_rx",   rx, 16'h01FF);
        check("r6_fdone", 16'(done_cnt - d0), 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
